// File: rtl/freq_divider_by3.sv
// freq_divider_by3: divide-by-3 clock generator with 50 % duty cycle.
// Rev 1.0 - initial release.
`default_nettype none

module freq_divider_by3 (
  input  logic clk,
  input  logic rst,
  output logic clk_out
);

  logic [1:0] cnt_q;
  logic [1:0] cnt_d;
  logic       pos_q;
  logic       neg_q;

  always_comb begin
    cnt_d = 2'd0;
    case (cnt_q)
      2'd0:    cnt_d = 2'd1;
      2'd1:    cnt_d = 2'd2;
      default: cnt_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= 2'd0;
      pos_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pos_q <= (cnt_q == 2'd2);
    end
  end

  // Half-cycle retime of pos_q stretches the high phase to 1.5 clk periods.
  always_ff @(negedge clk) begin
    if (!rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q;
    end
  end

  assign clk_out = pos_q | neg_q;

endmodule

`default_nettype wire

// File: tb/tb_freq_divider_by3.sv
// tb_freq_divider_by3: directed checks of output waveform, counter and reset behaviour.
`default_nettype none

module tb_freq_divider_by3;

  logic clk;
  logic rst;
  logic clk_out;

  int n_vec;
  int n_err;

  logic        mon_en;
  logic        last_out;
  logic        have_rise;
  logic        have_fall;
  logic [63:0] t_rise;
  logic [63:0] t_fall;

  freq_divider_by3 dut (
    .clk     (clk),
    .rst     (rst),
    .clk_out (clk_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Expected output after half-step h following reset release (h even: after a rise).
  function automatic logic exp_out(input int h);
    return (h >= 4) && (((h - 4) % 6) < 3);
  endfunction

  function automatic logic [1:0] exp_cnt(input int h);
    return 2'((h / 2 + 1) % 3);
  endfunction

  task automatic run_from_release(input int n_half);
    for (int h = 0; h < n_half; h++) begin
      if (h % 2 == 0) @(posedge clk);
      else            @(negedge clk);
      #1;
      check("clk_out", 32'(clk_out), 32'(exp_out(h)));
      check("cnt", 32'(dut.cnt_q), 32'(exp_cnt(h)));
    end
  endtask

  // Edge alignment and pulse-width monitor over every clk_out transition.
  always @(clk_out or mon_en) begin
    if (!mon_en) begin
      have_rise = 1'b0;
      have_fall = 1'b0;
    end else if (clk_out !== last_out) begin
      if (clk_out === 1'b1) begin
        check("rise_align", 32'($time % 10), 32'd5);
        if (have_fall) check("low_width", 32'($time - t_fall), 32'd15);
        t_rise    = $time;
        have_rise = 1'b1;
      end else begin
        check("fall_align", 32'($time % 10), 32'd0);
        if (have_rise) check("high_width", 32'($time - t_rise), 32'd15);
        t_fall    = $time;
        have_fall = 1'b1;
      end
    end
    last_out = clk_out;
  end

  initial begin
    n_vec    = 0;
    n_err    = 0;
    mon_en   = 1'b0;
    last_out = 1'b0;
    t_rise   = '0;
    t_fall   = '0;
    rst      = 1'b0;

    // Reset hold: after one full period with rst low, everything is cleared.
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_out_a", 32'(clk_out), 32'd0);
    check("rst_cnt_a", 32'(dut.cnt_q), 32'd0);
    @(posedge clk); #1;
    check("rst_out_b", 32'(clk_out), 32'd0);
    check("rst_cnt_b", 32'(dut.cnt_q), 32'd0);
    @(negedge clk); #1;
    check("rst_out_c", 32'(clk_out), 32'd0);

    rst    = 1'b1;
    mon_en = 1'b1;
    run_from_release(41);

    // h = 40 lands just after a rise with clk_out high; reset mid-pulse.
    check("pre_rst_high", 32'(clk_out), 32'd1);
    rst    = 1'b0;
    mon_en = 1'b0;
    @(negedge clk); #1;
    @(posedge clk); #1;
    check("mid_rst_drop", 32'(clk_out), 32'd0);
    check("mid_rst_cnt", 32'(dut.cnt_q), 32'd0);
    @(negedge clk); #1;
    check("mid_rst_hold_a", 32'(clk_out), 32'd0);
    @(posedge clk); #1;
    check("mid_rst_hold_b", 32'(clk_out), 32'd0);
    @(negedge clk); #1;

    rst    = 1'b1;
    mon_en = 1'b1;
    run_from_release(24);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/freq_divider_by3.md
# freq_divider_by3

Clock divider producing an output clock at one third of the input clock frequency with a 50 % duty cycle. It sits in the clocking/utility layer and drives lower-rate logic or observation pins from the system clock. The implementation uses a rising-edge mod-3 counter plus a falling-edge retimed copy, so the odd division ratio still yields a symmetric output.

## Interface
- No parameters. Division ratio fixed at 3, duty cycle fixed at 50 %.
- clk  input  1  system clock; all state is updated on its edges.
- rst  input  1  reset, synchronous and active-low (asserted when 0).
- clk_out  output  1  divided clock: period 3 × clk, high 1.5 clk periods, low 1.5 clk periods.

## Operation
- cnt: 2-bit counter, updated on the rising edge of clk.
  - Sequence is 0 → 1 → 2 → 0.
  - Value 3 is never entered; if it is ever seen, the next value is 0.
- pos_q: 1-bit register, updated on the rising edge of clk.
  - Loads (cnt == 2), i.e. it is 1 during exactly the cycle in which cnt == 0.
- neg_q: 1-bit register, updated on the falling edge of clk.
  - Loads pos_q, i.e. it is pos_q delayed by half a clk period.
- clk_out = pos_q | neg_q, combinational OR of two registered signals.
  - This is the only combinational term on the output path.
  - Glitch-free, because pos_q and neg_q overlap by half a cycle.
- Reset (rst == 0), synchronous:
  - At a rising edge: cnt ← 0, pos_q ← 0.
  - At a falling edge: neg_q ← 0.
  - clk_out is 0 once both a rising and a falling edge have occurred with rst low.
- Reset must be held low for at least one full clk period. Before that, state is undefined; no power-on value is required.
- Reset mid-operation: the output drops to 0 within half a clk period of the first edge sampling rst low.
  - A truncated high pulse is permitted.
  - After release, the sequence restarts from cnt = 0.
- No enable and no ratio change at runtime.

## Timing
- Let R0 be the first rising edge at which rst == 1.
  - R0: cnt 0→1.
  - R1: cnt 1→2.
  - R2: cnt 2→0 and pos_q → 1, so clk_out rises at R2.
- First falling edge after R2: neg_q → 1; clk_out stays 1.
- R3: pos_q → 0; clk_out stays 1 because neg_q is still 1.
- Falling edge after R3: neg_q → 0, so clk_out falls at R3 + T/2.
- Next rise is at R5, then R8, and so on: rising edges every 3 clk periods, each high phase exactly 1.5 T.
- Latency from reset release to the first clk_out rising edge: 3 clk rising edges (R0 to R2 inclusive).
- clk_out edges align with clk edges:
  - rising edges align with clk rising edges;
  - falling edges align with clk falling edges.
  - Output delay is clock-to-Q plus one OR gate.
- Both clk edges are used; timing analysis must cover half-cycle paths pos_q → neg_q.

## Test plan
- Reset hold: 10 ns clk (T = 10), rst = 0 for 20 ns -> clk_out = 0, cnt = 0 throughout, from the first full clk period onward.
- Startup latency: release rst before R0 -> clk_out 0 at R0 and R1, rises at R2 (20 ns after R0), falls at R3 + 5 ns.
- Steady state: run 200 ns after release -> clk_out period 30 ns, high 15 ns, low 15 ns, checked for every period; about 6 full periods.
- Edge alignment: check every clk_out rise coincides with a clk rise and every fall with a clk fall; no glitch (no pulse < 15 ns) anywhere.
- Mid-run reset: assert rst = 0 while clk_out is high -> clk_out = 0 within ≤ 5 ns of the next sampling edge; after release, the first rise is again at the third rising edge.
- Counter range: cnt only ever shows values 0, 1, 2; pos_q is high exactly one clk cycle in three.
